// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the
// branch/address unit (port 1); one operation in flight, response tagged with requester id.
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int OPW   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant;
    logic   accept;

    function automatic logic op_supported(input logic [OPW-1:0] op);
        return (op == OPW'(4'b0000)) || (op == OPW'(4'b0001)) ||
               (op == OPW'(4'b0010)) || (op == OPW'(4'b0110));
    endfunction

    // Contention goes to whichever requester did not win last time.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            if (state == IDLE && accept) begin
                alu_a      <= grant ? req1_a  : req0_a;
                alu_b      <= grant ? req1_b  : req0_b;
                alu_op     <= grant ? req1_op : req0_op;
                resp_id    <= grant;
                last_grant <= grant;
            end
            // Unsupported codes report a zero result regardless of what the ALU drives.
            if (state == EXEC) begin
                if (op_supported(alu_op)) begin
                    resp_result <= alu_result;
                    resp_zero   <= alu_zero;
                    resp_err    <= 1'b0;
                end else begin
                    resp_result <= '0;
                    resp_zero   <= 1'b1;
                    resp_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU wired to the arbiter's ALU port.
module tb_alu_arbiter;

    localparam int WIDTH = 64;
    localparam int OPW   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero;
    logic             resp_valid, resp_ready, resp_id, resp_zero, resp_err, busy;
    logic [WIDTH-1:0] resp_result;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Unknown codes drive a nonzero garbage result so a pass-through would be visible.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = 64'hDEAD_BEEF_0000_1234;
        endcase
        alu_zero = (alu_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110}) && (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic id, input logic [WIDTH-1:0] res,
                            input logic zero, input logic err);
        chk({tag, "_valid"},  64'(resp_valid),  64'd1);
        chk({tag, "_id"},     64'(resp_id),     64'(id));
        chk({tag, "_result"}, resp_result,      res);
        chk({tag, "_zero"},   64'(resp_zero),   64'(zero));
        chk({tag, "_err"},    64'(resp_err),    64'(err));
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_resp_result", resp_result, 64'd0);
        tick();
        reset = 1'b0;

        // Single request on port 0: 5 + 3
        req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'b0010;
        #1;
        chk("single_ready0", 64'(req0_ready), 64'd1);
        chk("single_ready1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_exec_busy", 64'(busy), 64'd1);
        chk("single_exec_rv", 64'(resp_valid), 64'd0);
        chk("single_exec_alu_a", alu_a, 64'd5);
        tick();
        chk_resp("single", 1'b0, 64'd8, 1'b0, 1'b0);
        resp_ready = 1'b1;
        tick();
        chk("single_done_rv", 64'(resp_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);
        resp_ready = 1'b0;

        // Contention after a fresh reset: 0 first, then 1, then 0 again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd7; req0_op = 4'b0110;
        req1_valid = 1'b1; req1_a = 64'hF0; req1_b = 64'h0F; req1_op = 4'b0000;
        #1;
        chk("cont1_ready0", 64'(req0_ready), 64'd1);
        chk("cont1_ready1", 64'(req1_ready), 64'd0);
        tick();
        tick();
        chk_resp("cont1", 1'b0, 64'd0, 1'b1, 1'b0);
        resp_ready = 1'b1;
        tick();
        chk("cont2_ready0", 64'(req0_ready), 64'd0);
        chk("cont2_ready1", 64'(req1_ready), 64'd1);
        tick();
        tick();
        chk_resp("cont2", 1'b1, 64'd0, 1'b1, 1'b0);
        tick();
        chk("cont3_ready0", 64'(req0_ready), 64'd1);
        chk("cont3_ready1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;

        // Wrap-around on port 1
        req1_valid = 1'b1; req1_a = '1; req1_b = 64'd1; req1_op = 4'b0010;
        #1;
        chk("wrap_add_ready1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk_resp("wrap_add", 1'b1, 64'd0, 1'b1, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd0; req1_b = 64'd1; req1_op = 4'b0110;
        tick();
        req1_valid = 1'b0;
        tick();
        chk_resp("wrap_sub", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Unsupported op code on port 0
        req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4; req0_op = 4'b0111;
        tick();
        req0_valid = 1'b0;
        tick();
        chk_resp("unsup", 1'b0, 64'd0, 1'b1, 1'b1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Back-pressure for 10 cycles with both requesters waiting
        req0_valid = 1'b1; req0_a = 64'hA0; req0_b = 64'h0B; req0_op = 4'b0001;
        tick();
        req0_a = 64'd10; req0_b = 64'd20; req0_op = 4'b0010;
        req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd2; req1_op = 4'b0010;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_result", resp_result, 64'hAB);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_readies", 64'({req0_ready, req1_ready}), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_release_rv", 64'(resp_valid), 64'd0);
        chk("bp_next_ready1", 64'(req1_ready), 64'd1);
        chk("bp_next_ready0", 64'(req0_ready), 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("bp_next_alu_a", alu_a, 64'd1);
        tick();
        chk_resp("bp_next", 1'b1, 64'd3, 1'b0, 1'b0);

        // Reset while in RESP
        reset = 1'b1;
        #1;
        chk("rst_resp_rv", 64'(resp_valid), 64'd0);
        chk("rst_resp_busy", 64'(busy), 64'd0);
        chk("rst_resp_result", resp_result, 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_alu_op", 64'(alu_op), 64'd0);
        tick();
        reset = 1'b0;

        // Reset while in EXEC, after a port-0 win
        req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd9; req0_op = 4'b0010;
        tick();
        req0_valid = 1'b0;
        chk("rst_exec_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_exec_busy", 64'(busy), 64'd0);
        chk("rst_exec_alu_a", alu_a, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_exec_no_resp", 64'(resp_valid), 64'd0);

        // last_grant restored by reset: port 0 wins contention
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_cont_ready0", 64'(req0_ready), 64'd1);
        chk("rst_cont_ready1", 64'(req1_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
